alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one 4-bit combinational ALU (A, B, ALUop -> Result) between two requesters.
- Round-robin arbitration with valid/ready request and response handshakes.
- Registered ALU operands and a registered, held result.
- Sits between the two client blocks and the single ALU instance at the datapath top level. Only this block drives the ALU inputs.

Parameters:
WIDTH, 4, operand/result width (matches ALU A/B/Result)
OPW, 2, ALU opcode width (matches ALUop)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  2  per-requester request valid (bit i = requester i)
req_ready  output  2  per-requester accept; at most one bit high
req_a  input  2*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH]
req_b  input  2*WIDTH  operand B, same packing
req_op  input  2*OPW  opcode, requester i in bits [i*OPW +: OPW]
rsp_valid  output  2  result valid to owning requester; at most one bit high
rsp_ready  input  2  per-requester result accept
rsp_result  output  WIDTH  held result (shared bus, qualified by rsp_valid)
alu_a  output  WIDTH  to ALU A
alu_b  output  WIDTH  to ALU B
alu_op  output  OPW  to ALU ALUop
alu_result  input  WIDTH  from ALU Result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, alu_a=0, alu_b=0, alu_op=0, rsp_result=0, owner=0, prio=0 (requester 0 favoured), busy=0. req_ready and rsp_valid are 0 because state=IDLE with no grant and no response pending.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant logic (combinational):
  - Only one valid bit set -> that requester wins.
  - Both set -> requester `prio` wins.
  - req_ready = onehot(grant), only while in IDLE.
- IDLE, on a clock edge with any valid:
  - Register the winner's a/b/op into alu_a/alu_b/alu_op.
  - owner <= winner; state -> EXEC.
  - With no valid bit set, stay in IDLE and hold all registers.
- EXEC: lasts exactly one cycle (the ALU settles).
  - rsp_result <= alu_result at the edge; state -> RESP.
- RESP:
  - rsp_valid[owner] = 1.
  - rsp_ready[owner]=1 at an edge -> state -> IDLE and prio <= ~owner, so the last served requester gets lowest priority.
  - rsp_ready of the non-owner is ignored.
  - rsp_result and alu_* are held stable throughout RESP.
- Latency: accept at edge T -> rsp_valid high in cycle T+2. Best-case throughput is 1 op per 3 cycles. rsp_ready high on arrival means IDLE again at T+3.
- Request protocol: req_valid is held with stable payload until req_ready. Payload is sampled only at the accept edge; later changes have no effect.
- New requests arriving during EXEC/RESP wait (req_ready=0). Arbitration is re-evaluated in IDLE using the prio value updated at the preceding response.
- Starvation-free: with both requesters continuously valid, grants alternate 0,1,0,1...
- Width/arithmetic: no arithmetic in this block. alu_result passes through unmodified; the ALU's overflow/wrap behaviour is the ALU's.
- Reset mid-operation (EXEC or RESP): the transaction is dropped, rsp_valid falls immediately (async), and the block returns to reset values.
- alu_* are driven only from registers, so no combinational path exists from req_* to the ALU.

Decomposition:
- Shared package/header: WIDTH/OPW defaults, FSM state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), ALU opcode constants 2'b00..2'b11 shared with the ALU.
- One natural sub-module: rr_arbiter2. Inputs: 2-bit valid, prio. Output: one-hot grant. Purely combinational; prio is updated in the parent.
- The ALU stays a separate instance at the top, not inside this block.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release, no valid -> req_ready=00, rsp_valid=00, busy=0, alu_a=alu_b=alu_op=0 for 10 cycles.
- Single request: req0 A=4'b0100 B=4'b0001 op=2'b11 -> req_ready=01 in the accept cycle; alu_a/b/op=0100/0001/11 from T+1; rsp_valid=01 at T+2 with rsp_result equal to ALU(0100,0001,11). Repeat for ops 10, 01, 00.
- Contention and fairness: both valid continuously (req0 op=00, req1 op=01), rsp_ready=11 -> grant order 0,1,0,1, each response routed to the correct owner bit, one completion every 3 cycles.
- Response backpressure: rsp_ready[0]=0 for 5 cycles after rsp_valid=01 -> rsp_valid and rsp_result held, req1 not accepted; raising rsp_ready[1] alone has no effect. Raising rsp_ready[0] returns to IDLE, then req1 is granted.
- Payload change after accept: change req_a/req_op in EXEC -> alu_a/alu_op and rsp_result unaffected.
- Reset mid-op: assert rst during EXEC and, separately, during RESP -> rsp_valid drops in the same cycle (async), all outputs at reset values, no spurious response after release.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: default widths,
// FSM state encodings and the opcode values shared with the ALU.
package alu_arbiter_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int OPW_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] ALU_OP_0 = 2'b00;
  localparam logic [1:0] ALU_OP_1 = 2'b01;
  localparam logic [1:0] ALU_OP_2 = 2'b10;
  localparam logic [1:0] ALU_OP_3 = 2'b11;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way combinational round-robin grant; the priority bit is owned by
// the parent and names the requester that wins a tie.
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  // one-hot grant from the valid pattern and tie-break priority
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin
// arbitration, registered ALU operands and a held, registered result.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*OPW-1:0]   req_op,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  output logic               busy
);

  state_t     state_r;
  state_t     next_state_s;
  logic       owner_r;
  logic       prio_r;
  logic [1:0] grant_s;
  logic       win_s;
  logic       accept_s;
  logic       release_s;

  rr_arbiter2 u_rr (
    .valid (req_valid),
    .prio  (prio_r),
    .grant (grant_s)
  );

  assign win_s     = grant_s[1];
  assign accept_s  = (state_r == IDLE) && (|req_valid);
  assign release_s = (state_r == RESP) && rsp_ready[owner_r];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = (|req_valid) ? EXEC : IDLE;
      EXEC:    next_state_s = RESP;
      RESP:    next_state_s = rsp_ready[owner_r] ? IDLE : RESP;
      default: next_state_s = IDLE;
    endcase
  end

  // operand capture, result capture and round-robin priority update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= {WIDTH{1'b0}};
      alu_b      <= {WIDTH{1'b0}};
      alu_op     <= {OPW{1'b0}};
      rsp_result <= {WIDTH{1'b0}};
      owner_r    <= 1'b0;
      prio_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        alu_a   <= win_s ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        alu_b   <= win_s ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        alu_op  <= win_s ? req_op[2*OPW-1:OPW]    : req_op[OPW-1:0];
        owner_r <= win_s;
      end
      if (state_r == EXEC) begin
        rsp_result <= alu_result;
      end
      // the requester just served drops to lowest priority
      if (release_s) begin
        prio_r <= ~owner_r;
      end
    end
  end

  // handshake outputs decoded from the state register
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = 1'b0;
    case (state_r)
      IDLE: req_ready = grant_s;
      EXEC: busy = 1'b1;
      RESP: begin
        busy      = 1'b1;
        rsp_valid = owner_r ? 2'b10 : 2'b01;
      end
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised self-checking bench for alu_arbiter with a behavioural ALU
// and a transaction-level model of arbitration order and latency.
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_a, req_b;
  logic [3:0] req_op;
  logic [3:0] rsp_result, alu_a, alu_b, alu_result;
  logic [1:0] alu_op;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int last_served = 1;  // after reset requester 0 is favoured

  alu_arbiter #(.WIDTH(4), .OPW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .busy(busy)
  );

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return 1 - last_served;
  endfunction

  task automatic run_txn(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input int stall);
    int w;
    logic [1:0] oh;
    logic [3:0] ea, eb, er;
    logic [1:0] eo;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; req_op = op; rsp_ready = 2'b00;
    w = pick(v);
    oh = (w == 1) ? 2'b10 : 2'b01;
    ea = a[w*4 +: 4]; eb = b[w*4 +: 4]; eo = op[w*2 +: 2];
    er = alu_ref(ea, eb, eo);
    #1;
    total_cnt++; if (req_ready !== oh) $display("FAIL txn_req_ready got=%b exp=%b", req_ready, oh); else pass_cnt++;
    @(negedge clk);
    req_valid = 2'b00; req_a = ~req_a; req_b = ~req_b; req_op = ~req_op;
    #1;
    total_cnt++; if ({alu_a, alu_b, alu_op} !== {ea, eb, eo})
      $display("FAIL txn_alu_operands got=%h/%h/%b exp=%h/%h/%b", alu_a, alu_b, alu_op, ea, eb, eo); else pass_cnt++;
    total_cnt++; if ({busy, req_ready, rsp_valid} !== 5'b10000)
      $display("FAIL txn_exec_flags got=%b exp=10000", {busy, req_ready, rsp_valid}); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++; if (rsp_valid !== oh) $display("FAIL txn_rsp_valid got=%b exp=%b", rsp_valid, oh); else pass_cnt++;
    total_cnt++; if (rsp_result !== er) $display("FAIL txn_rsp_result got=%h exp=%h", rsp_result, er); else pass_cnt++;
    for (int i = 0; i < stall; i++) begin
      rsp_ready = ~oh;
      @(negedge clk);
      #1;
      total_cnt++; if ({rsp_valid, rsp_result} !== {oh, er})
        $display("FAIL txn_stall_hold got=%b/%h exp=%b/%h", rsp_valid, rsp_result, oh, er); else pass_cnt++;
    end
    rsp_ready = ($urandom_range(0, 1) == 1) ? 2'b11 : oh;
    @(negedge clk);
    rsp_ready = 2'b00;
    last_served = w;
    #1;
    total_cnt++; if ({busy, rsp_valid} !== 3'b000) $display("FAIL txn_back_idle got=%b exp=000", {busy, rsp_valid}); else pass_cnt++;
  endtask

  task automatic test_reset();
    req_valid = 2'b00; rsp_ready = 2'b00; req_a = 8'h00; req_b = 8'h00; req_op = 4'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_served = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      total_cnt++; if ({req_ready, rsp_valid, busy} !== 5'b00000)
        $display("FAIL reset_flags cyc=%0d got=%b exp=00000", i, {req_ready, rsp_valid, busy}); else pass_cnt++;
      total_cnt++; if ({alu_a, alu_b, alu_op, rsp_result} !== 14'h0)
        $display("FAIL reset_regs cyc=%0d got=%h exp=0", i, {alu_a, alu_b, alu_op, rsp_result}); else pass_cnt++;
    end
  endtask

  task automatic test_single();
    logic [3:0] ops;
    ops = 4'b1110;  // unused; ops iterate 11,10,01,00 below
    for (int k = 3; k >= 0; k--) begin
      run_txn(2'b01, 8'hA4, 8'h51, {2'b00, 2'(k)}, 0);
    end
  endtask

  task automatic test_contention();
    int first;
    int who;
    logic [1:0] oh;
    logic [3:0] er;
    @(negedge clk);
    first = 1 - last_served;
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_a = 8'h3C; req_b = 8'h25; req_op = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      who = (first + k / 3) % 2;
      oh = (who == 1) ? 2'b10 : 2'b01;
      er = (who == 1) ? alu_ref(4'h3, 4'h2, 2'b01) : alu_ref(4'hC, 4'h5, 2'b00);
      #1;
      if (k % 3 == 0) begin
        total_cnt++; if (req_ready !== oh) $display("FAIL contention_grant k=%0d got=%b exp=%b", k, req_ready, oh); else pass_cnt++;
      end else if (k % 3 == 2) begin
        total_cnt++; if ({rsp_valid, rsp_result} !== {oh, er})
          $display("FAIL contention_rsp k=%0d got=%b/%h exp=%b/%h", k, rsp_valid, rsp_result, oh, er); else pass_cnt++;
        last_served = who;
      end else begin
        total_cnt++; if ({req_ready, rsp_valid} !== 4'b0000)
          $display("FAIL contention_exec k=%0d got=%b exp=0000", k, {req_ready, rsp_valid}); else pass_cnt++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [3:0] er;
    @(negedge clk);
    req_valid = 2'b01; req_a = 8'h97; req_b = 8'h23; req_op = 4'b0001;
    er = alu_ref(4'h7, 4'h3, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    req_valid = 2'b10; rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++; if ({rsp_valid, rsp_result, req_ready} !== {2'b01, er, 2'b00})
        $display("FAIL backpressure_hold i=%0d got=%b/%h/%b exp=01/%h/00", i, rsp_valid, rsp_result, req_ready, er); else pass_cnt++;
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    last_served = 0;
    #1;
    total_cnt++; if (req_ready !== 2'b10) $display("FAIL backpressure_next_grant got=%b exp=10", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    total_cnt++; if ({rsp_valid, rsp_result} !== {2'b10, alu_ref(4'h9, 4'h2, 2'b00)})
      $display("FAIL backpressure_req1_rsp got=%b/%h", rsp_valid, rsp_result); else pass_cnt++;
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    last_served = 1;
  endtask

  task automatic test_reset_midop(input int extra);
    @(negedge clk);
    req_valid = 2'b01; req_a = 8'h0F; req_b = 8'h0E; req_op = 4'b0010;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (extra) @(negedge clk);
    #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL midop_busy_before extra=%0d got=%b exp=1", extra, busy); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if ({rsp_valid, req_ready, busy} !== 5'b00000)
      $display("FAIL midop_async_drop extra=%0d got=%b exp=00000", extra, {rsp_valid, req_ready, busy}); else pass_cnt++;
    total_cnt++; if ({alu_a, alu_b, alu_op, rsp_result} !== 14'h0)
      $display("FAIL midop_regs extra=%0d got=%h exp=0", extra, {alu_a, alu_b, alu_op, rsp_result}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    last_served = 1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total_cnt++; if ({rsp_valid, busy} !== 3'b000)
        $display("FAIL midop_no_spurious extra=%0d got=%b exp=000", extra, {rsp_valid, busy}); else pass_cnt++;
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0] v;
    for (int n = 0; n < 24; n++) begin
      v = 2'($urandom_range(1, 3));
      run_txn(v, 8'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    run_txn(2'b11, 8'h12, 8'h34, 4'b1001, 1);
    test_reset_midop(0);
    test_reset_midop(1);
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
